// File: rtl/mac_req_sequencer.sv
// -----------------------------------------------------------------------------
// mac_req_sequencer
//
// Purpose:
//   Round-robin scheduler that lets two host-side requesters share one MAC
//   frame input interface. A grant latches the winner's operands, drives the
//   two-cycle byte protocol (Data A + control, then Data B), waits RESULT_LAT
//   cycles, samples the MAC result/overflow and returns them to the winner with
//   a one-cycle response pulse.
//
// Parameters:
//   RESULT_LAT          cycles spent in WAIT before mac_result is sampled (1..15)
//
// Ports:
//   clk                 clock
//   rst_n               asynchronous active-low reset
//   req[1:0]            request per requester (bit i = requester i)
//   req_a[15:0]         Data A operands, [7:0] requester 0, [15:8] requester 1
//   req_b[15:0]         Data B operands, same packing
//   req_clr[1:0]        clear_and_mult per requester
//   req_signed[1:0]     signed_mode per requester
//   resp_valid[1:0]     one-hot, one-cycle response pulse to the granted requester
//   resp_result[15:0]   sampled MAC result, held until the next response
//   resp_overflow       sampled MAC overflow, held
//   resp_error          1 = no frame_valid seen during WAIT, held
//   busy                high in every state except IDLE
//   frame_cnt[7:0]      completed frames, wraps 255 -> 0
//   mac_enable          input-interface enable
//   mac_data[7:0]       byte to the input interface
//   mac_clear_and_mult  control, valid in the SEND_A cycle
//   mac_signed_mode     control, valid in the SEND_A cycle
//   mac_frame_valid     frame-complete pulse from the input interface
//   mac_result[15:0]    MAC result
//   mac_overflow        MAC overflow
// -----------------------------------------------------------------------------
module mac_req_sequencer #(
   parameter int RESULT_LAT = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  req,
   input  logic [15:0] req_a,
   input  logic [15:0] req_b,
   input  logic [1:0]  req_clr,
   input  logic [1:0]  req_signed,
   output logic [1:0]  resp_valid,
   output logic [15:0] resp_result,
   output logic        resp_overflow,
   output logic        resp_error,
   output logic        busy,
   output logic [7:0]  frame_cnt,
   output logic        mac_enable,
   output logic [7:0]  mac_data,
   output logic        mac_clear_and_mult,
   output logic        mac_signed_mode,
   input  logic        mac_frame_valid,
   input  logic [15:0] mac_result,
   input  logic        mac_overflow
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SEND_A = 3'd1,
      SEND_B = 3'd2,
      WAIT   = 3'd3,
      DONE   = 3'd4
   } state_t;

   // Value of the wait counter in the final WAIT cycle.
   localparam logic [3:0] LAST_WAIT = 4'(RESULT_LAT - 1);

   state_t      state_reg;
   logic        grant_reg;
   logic        last_grant_reg;
   logic [7:0]  b_reg;
   logic [3:0]  wait_cnt_reg;
   logic        fv_seen_reg;
   logic        grant_next;

   // Per-requester operand lanes, indexed by requester number.
   logic [7:0]  lane_a   [0:1];
   logic [7:0]  lane_b   [0:1];
   logic        lane_clr [0:1];
   logic        lane_sgn [0:1];

   for (genvar gi = 0; gi < 2; gi++) begin : g_lane
      assign lane_a[gi]   = req_a[8*gi +: 8];
      assign lane_b[gi]   = req_b[8*gi +: 8];
      assign lane_clr[gi] = req_clr[gi];
      assign lane_sgn[gi] = req_signed[gi];
   end

   // Single requester wins outright; on a tie the one not served last wins.
   always_comb begin
      grant_next = 1'b0;
      case (req)
         2'b01:   grant_next = 1'b0;
         2'b10:   grant_next = 1'b1;
         default: grant_next = ~last_grant_reg;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg          <= IDLE;
         grant_reg          <= 1'b0;
         last_grant_reg     <= 1'b1;
         b_reg              <= 8'd0;
         wait_cnt_reg       <= 4'd0;
         fv_seen_reg        <= 1'b0;
         resp_valid         <= 2'b00;
         resp_result        <= 16'd0;
         resp_overflow      <= 1'b0;
         resp_error         <= 1'b0;
         busy               <= 1'b0;
         frame_cnt          <= 8'd0;
         mac_enable         <= 1'b0;
         mac_data           <= 8'd0;
         mac_clear_and_mult <= 1'b0;
         mac_signed_mode    <= 1'b0;
      end else begin
         // The response is a single-cycle pulse unless re-asserted below.
         resp_valid <= 2'b00;

         case (state_reg)
            IDLE: begin
               if (req != 2'b00) begin
                  // The SEND_A output registers double as the latched
                  // Data A / control of the winner; only Data B needs a
                  // separate holding register.
                  grant_reg          <= grant_next;
                  b_reg              <= lane_b[grant_next];
                  mac_enable         <= 1'b1;
                  mac_data           <= lane_a[grant_next];
                  mac_clear_and_mult <= lane_clr[grant_next];
                  mac_signed_mode    <= lane_sgn[grant_next];
                  busy               <= 1'b1;
                  state_reg          <= SEND_A;
               end
            end

            SEND_A: begin
               mac_data           <= b_reg;
               mac_clear_and_mult <= 1'b0;
               mac_signed_mode    <= 1'b0;
               state_reg          <= SEND_B;
            end

            SEND_B: begin
               mac_enable   <= 1'b0;
               mac_data     <= 8'd0;
               fv_seen_reg  <= 1'b0;
               wait_cnt_reg <= 4'd0;
               state_reg    <= WAIT;
            end

            WAIT: begin
               fv_seen_reg  <= fv_seen_reg | mac_frame_valid;
               wait_cnt_reg <= wait_cnt_reg + 4'd1;
               if (wait_cnt_reg == LAST_WAIT) begin
                  // A frame_valid arriving in this very cycle still counts.
                  resp_result   <= mac_result;
                  resp_overflow <= mac_overflow;
                  resp_error    <= ~(fv_seen_reg | mac_frame_valid);
                  resp_valid    <= 2'b01 << grant_reg;
                  state_reg     <= DONE;
               end
            end

            DONE: begin
               last_grant_reg <= grant_reg;
               frame_cnt      <= frame_cnt + 8'd1;
               busy           <= 1'b0;
               state_reg      <= IDLE;
            end

            default: begin
               mac_enable <= 1'b0;
               mac_data   <= 8'd0;
               busy       <= 1'b0;
               state_reg  <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mac_req_sequencer.sv
module tb_mac_req_sequencer;

   localparam int LAT = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  req = 2'b00;
   logic [15:0] req_a = 16'd0;
   logic [15:0] req_b = 16'd0;
   logic [1:0]  req_clr = 2'b00;
   logic [1:0]  req_signed = 2'b00;
   logic [1:0]  resp_valid;
   logic [15:0] resp_result;
   logic        resp_overflow;
   logic        resp_error;
   logic        busy;
   logic [7:0]  frame_cnt;
   logic        mac_enable;
   logic [7:0]  mac_data;
   logic        mac_clear_and_mult;
   logic        mac_signed_mode;
   logic        mac_frame_valid;
   logic [15:0] mac_result;
   logic        mac_overflow;

   int n_pass  = 0;
   int n_total = 0;
   int cyc     = 0;

   // Reference state: round-robin pointer and completed-frame count.
   bit model_last = 1'b1;
   int model_cnt  = 0;
   int prev_grant_cyc = 0;

   // Stub controls.
   bit fv_en   = 1'b1;
   bit spur_en = 1'b0;

   mac_req_sequencer #(.RESULT_LAT(LAT)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .req_a(req_a), .req_b(req_b),
      .req_clr(req_clr), .req_signed(req_signed), .resp_valid(resp_valid),
      .resp_result(resp_result), .resp_overflow(resp_overflow),
      .resp_error(resp_error), .busy(busy), .frame_cnt(frame_cnt),
      .mac_enable(mac_enable), .mac_data(mac_data),
      .mac_clear_and_mult(mac_clear_and_mult), .mac_signed_mode(mac_signed_mode),
      .mac_frame_valid(mac_frame_valid), .mac_result(mac_result),
      .mac_overflow(mac_overflow)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Toy MAC: product (signed or unsigned) of the two bytes; without clear the
   // product is scrambled so the control bit is visible in the result.
   // Overflow flags equal operands. Returns {overflow, result}.
   function automatic logic [16:0] mac_func(input logic [7:0] a, input logic [7:0] b,
                                            input logic clr, input logic sgn);
      int p;
      logic [15:0] r;
      if (sgn) p = int'($signed(a)) * int'($signed(b));
      else     p = int'(a) * int'(b);
      r = p[15:0];
      if (!clr) r = r ^ 16'h5A5A;
      return {(a == b), r};
   endfunction

   // MAC input-interface stub: captures the byte pair from the bus, answers in
   // the first WAIT cycle, optionally pulses frame_valid spuriously in SEND_B.
   logic       phase;
   logic [7:0] st_a;
   logic       st_clr, st_sgn;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase <= 1'b0; st_a <= 8'd0; st_clr <= 1'b0; st_sgn <= 1'b0;
         mac_frame_valid <= 1'b0; mac_result <= 16'd0; mac_overflow <= 1'b0;
      end else begin
         mac_frame_valid <= 1'b0;
         if (mac_enable && !phase) begin
            phase <= 1'b1; st_a <= mac_data;
            st_clr <= mac_clear_and_mult; st_sgn <= mac_signed_mode;
            mac_frame_valid <= spur_en;
         end else if (mac_enable && phase) begin
            phase <= 1'b0;
            {mac_overflow, mac_result} <= mac_func(st_a, mac_data, st_clr, st_sgn);
            mac_frame_valid <= fv_en;
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
   endtask

   // Drive one frame and check every cycle from grant to the return to IDLE.
   // Timeline after the grant edge: SEND_A, SEND_B, LAT x WAIT, DONE, IDLE.
   task automatic run_frame(input logic [1:0] r, input logic [15:0] a, input logic [15:0] b,
                            input logic [1:0] clr, input logic [1:0] sgn,
                            input bit fv, input bit spur, input bit drop, input bit spacing,
                            input bit eg, input logic [15:0] eres, input bit eovf,
                            input bit eerr, input string nm);
      logic [7:0] ea, eb;
      bit ec, es, granted;
      ea = eg ? a[15:8] : a[7:0];
      eb = eg ? b[15:8] : b[7:0];
      ec = clr[eg];
      es = sgn[eg];
      @(negedge clk);
      req = r; req_a = a; req_b = b; req_clr = clr; req_signed = sgn;
      fv_en = fv; spur_en = spur;
      granted = 1'b0;
      for (int i = 0; i < 8 && !granted; i++) begin
         @(posedge clk); #1;
         granted = busy;
      end
      chk({nm, " grant"}, 32'(granted), 32'd1);
      if (!granted) return;
      if (spacing) chk({nm, " burst_spacing"}, cyc - prev_grant_cyc, 4 + LAT);
      prev_grant_cyc = cyc;
      // SEND_A
      chk({nm, " A_enable"}, 32'(mac_enable), 32'd1);
      chk({nm, " A_data"}, 32'(mac_data), 32'(ea));
      chk({nm, " A_clr"}, 32'(mac_clear_and_mult), 32'(ec));
      chk({nm, " A_signed"}, 32'(mac_signed_mode), 32'(es));
      // Operands change (and req may drop) after the grant; must be ignored.
      if (drop) req = 2'b00;
      req_a = 16'($urandom); req_b = 16'($urandom);
      req_clr = 2'($urandom); req_signed = 2'($urandom);
      @(posedge clk); #1;  // SEND_B
      chk({nm, " B_enable"}, 32'(mac_enable), 32'd1);
      chk({nm, " B_data"}, 32'(mac_data), 32'(eb));
      chk({nm, " B_ctrl"}, 32'({mac_clear_and_mult, mac_signed_mode}), 32'd0);
      for (int k = 0; k < LAT; k++) begin
         @(posedge clk); #1;  // WAIT
         chk({nm, " W_enable"}, 32'({mac_enable, mac_data}), 32'd0);
         chk({nm, " W_resp_valid"}, 32'(resp_valid), 32'd0);
      end
      @(posedge clk); #1;  // DONE
      chk({nm, " resp_valid"}, 32'(resp_valid), eg ? 32'd2 : 32'd1);
      chk({nm, " resp_result"}, 32'(resp_result), 32'(eres));
      chk({nm, " resp_overflow"}, 32'(resp_overflow), 32'(eovf));
      chk({nm, " resp_error"}, 32'(resp_error), 32'(eerr));
      chk({nm, " D_busy"}, 32'(busy), 32'd1);
      model_last = eg;
      model_cnt  = (model_cnt + 1) % 256;
      @(posedge clk); #1;  // IDLE
      chk({nm, " I_resp_valid"}, 32'(resp_valid), 32'd0);
      chk({nm, " I_busy"}, 32'(busy), 32'd0);
      chk({nm, " frame_cnt"}, 32'(frame_cnt), 32'(model_cnt));
      chk({nm, " hold_result"}, 32'(resp_result), 32'(eres));
      $display("frame %s: req=%b grant=%0d a=%h b=%h result=%h ovf=%b err=%b cnt=%0d",
               nm, r, eg, ea, eb, resp_result, resp_overflow, resp_error, frame_cnt);
   endtask

   // Expectations from the arbitration rule and the toy MAC.
   task automatic run_model(input logic [1:0] r, input logic [15:0] a, input logic [15:0] b,
                            input logic [1:0] clr, input logic [1:0] sgn,
                            input bit fv, input bit spur, input bit drop, input string nm);
      bit eg;
      logic [16:0] m;
      eg = (r == 2'b01) ? 1'b0 : (r == 2'b10) ? 1'b1 : ~model_last;
      m  = mac_func(eg ? a[15:8] : a[7:0], eg ? b[15:8] : b[7:0], clr[eg], sgn[eg]);
      run_frame(r, a, b, clr, sgn, fv, spur, drop, 1'b0, eg, m[15:0], m[16], !fv, nm);
   endtask

   // Start a frame, advance 'depth' cycles past SEND_A, then pull reset mid-cycle.
   task automatic reset_mid(input logic [1:0] r, input int depth, input string nm);
      bit granted;
      int rv_seen;
      @(negedge clk);
      req = r; req_a = 16'($urandom); req_b = 16'($urandom); fv_en = 1'b1; spur_en = 1'b0;
      granted = 1'b0;
      for (int i = 0; i < 8 && !granted; i++) begin
         @(posedge clk); #1;
         granted = busy;
      end
      chk({nm, " grant"}, 32'(granted), 32'd1);
      repeat (depth) begin @(posedge clk); #1; end
      chk({nm, " pre_enable"}, 32'(mac_enable), (depth < 2) ? 32'd1 : 32'd0);
      chk({nm, " pre_busy"}, 32'(busy), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk({nm, " rst_busy"}, 32'(busy), 32'd0);
      chk({nm, " rst_enable"}, 32'(mac_enable), 32'd0);
      chk({nm, " rst_resp_valid"}, 32'(resp_valid), 32'd0);
      chk({nm, " rst_frame_cnt"}, 32'(frame_cnt), 32'd0);
      req = 2'b00;
      model_last = 1'b1;
      model_cnt  = 0;
      rv_seen = 0;
      for (int i = 0; i < 8; i++) begin
         if (i == 2) begin @(negedge clk); rst_n = 1'b1; end
         @(posedge clk); #1;
         if (resp_valid != 2'b00) rv_seen++;
      end
      chk({nm, " no_response"}, rv_seen, 0);
   endtask

   typedef struct {
      logic [1:0]  r;
      logic [15:0] a, b;
      logic [1:0]  clr, sgn;
      bit          fv;
      bit          eg;
      logic [15:0] eres;
      bit          eovf, eerr;
   } vec_t;

   vec_t tbl [8];

   initial begin
      logic [15:0] ra, rb;
      logic [1:0]  rr, rc, rs;
      logic [16:0] m;
      bit          eg;

      //          req    a          b          clr    sgn    fv  grant result     ovf err
      tbl[0] = '{2'b01, 16'hAA03, 16'h5504, 2'b01, 2'b10, 1, 0, 16'h000C, 0, 0};
      tbl[1] = '{2'b10, 16'hFE11, 16'h0322, 2'b10, 2'b10, 1, 1, 16'hFFFA, 0, 0};
      tbl[2] = '{2'b11, 16'h3310, 16'h4410, 2'b01, 2'b10, 1, 0, 16'h0100, 1, 0};
      tbl[3] = '{2'b11, 16'h8066, 16'h8077, 2'b10, 2'b10, 1, 1, 16'h4000, 1, 0};
      tbl[4] = '{2'b01, 16'h0902, 16'h0905, 2'b10, 2'b00, 1, 0, 16'h5A50, 0, 0};
      tbl[5] = '{2'b10, 16'h0701, 16'h0902, 2'b11, 2'b01, 0, 1, 16'h003F, 0, 1};
      tbl[6] = '{2'b10, 16'h0105, 16'h0106, 2'b10, 2'b00, 1, 1, 16'h0001, 1, 0};
      tbl[7] = '{2'b11, 16'h12FF, 16'h34FF, 2'b01, 2'b00, 1, 0, 16'hFE01, 1, 0};

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      chk("reset resp_valid", 32'(resp_valid), 32'd0);
      chk("reset resp_result", 32'(resp_result), 32'd0);
      chk("reset resp_flags", 32'({resp_overflow, resp_error}), 32'd0);
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset frame_cnt", 32'(frame_cnt), 32'd0);
      chk("reset mac_enable", 32'(mac_enable), 32'd0);
      chk("reset mac_data", 32'(mac_data), 32'd0);
      chk("reset mac_ctrl", 32'({mac_clear_and_mult, mac_signed_mode}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // req = 00 in IDLE: nothing happens.
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         chk("idle busy", 32'({busy, mac_enable}), 32'd0);
      end
      chk("idle frame_cnt", 32'(frame_cnt), 32'd0);

      // Table-driven frames.
      for (int i = 0; i < 8; i++)
         run_frame(tbl[i].r, tbl[i].a, tbl[i].b, tbl[i].clr, tbl[i].sgn, tbl[i].fv,
                   1'b0, 1'b0, 1'b0, tbl[i].eg, tbl[i].eres, tbl[i].eovf, tbl[i].eerr,
                   $sformatf("tbl%0d", i));
      req = 2'b00;

      // Reset during WAIT, then a fresh req=10 is granted first.
      reset_mid(2'b01, 2, "rst_wait");
      run_model(2'b10, 16'h2211, 16'h4433, 2'b11, 2'b00, 1'b1, 1'b0, 1'b0, "post_rst");

      // Both held high: grants alternate 0,1,0,1 with a burst every 4+LAT cycles.
      for (int i = 0; i < 4; i++) begin
         ra = 16'($urandom); rb = 16'($urandom); rc = 2'($urandom); rs = 2'($urandom);
         eg = (i % 2 == 1);
         m  = mac_func(eg ? ra[15:8] : ra[7:0], eg ? rb[15:8] : rb[7:0], rc[eg], rs[eg]);
         run_frame(2'b11, ra, rb, rc, rs, 1'b1, 1'b0, 1'b0, (i > 0), eg, m[15:0], m[16],
                   1'b0, $sformatf("alt%0d", i));
      end

      // Spurious frame_valid outside WAIT does not count; next good frame clears error.
      run_model(2'b01, 16'h0505, 16'h0606, 2'b01, 2'b00, 1'b0, 1'b1, 1'b0, "spurious");
      run_model(2'b01, 16'h0707, 16'h0808, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0, "recover");
      req = 2'b00;

      // Reset during SEND_A; afterwards a tie goes to requester 0.
      reset_mid(2'b10, 0, "rst_senda");
      run_model(2'b11, 16'hC3A5, 16'h3C5A, 2'b01, 2'b10, 1'b1, 1'b0, 1'b0, "tie_after_rst");

      // Randomized frames against the model; frame_cnt wraps past 255.
      for (int i = 0; i < 260; i++) begin
         rr = 2'($urandom_range(1, 3));
         ra = 16'($urandom); rb = 16'($urandom); rc = 2'($urandom); rs = 2'($urandom);
         run_model(rr, ra, rb, rc, rs, ($urandom_range(0, 7) != 0), 1'b0,
                   ($urandom_range(0, 3) == 0), $sformatf("rnd%0d", i));
      end
      req = 2'b00;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
